// File: rtl/risc_pack.sv
// Shared pipeline definitions for the qrisc32 core.
// Holds the MEM->WB payload struct and the architectural register-file sizing
// constants that set the write-back stage defaults.
package risc_pack;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned XLEN    = 32;

    // MEM-stage output consumed by write-back
    typedef struct packed {
        logic              write_reg;
        logic [REG_AW-1:0] dst_r;
        logic [XLEN-1:0]   val_dst;
        logic              incr_r2_enable;
        logic [REG_AW-1:0] src_r2;
        logic [XLEN-1:0]   val_r2;
    } pipe_struct;

endpackage

// File: rtl/qrisc32_regfile.sv
// Architectural register file: NREGS x DATA_W storage, two write ports with
// port-A priority on collision, two combinational read ports that bypass the
// value being written this cycle.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_we_a/i_waddr_a/i_wdata_a write port A (priority)
//   i_we_b/i_waddr_b/i_wdata_b write port B
//   i_raddr1 -> o_rdata1_c     read port 1 (combinational)
//   i_raddr2 -> o_rdata2_c     read port 2 (combinational)
module qrisc32_regfile
    import risc_pack::*;
#(
    parameter int unsigned NREGS  = REG_NUM,
    parameter int unsigned DATA_W = XLEN,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we_a,
    input  logic [AW-1:0]     i_waddr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    input  logic              i_we_b,
    input  logic [AW-1:0]     i_waddr_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    input  logic [AW-1:0]     i_raddr1,
    output logic [DATA_W-1:0] o_rdata1_c,
    input  logic [AW-1:0]     i_raddr2,
    output logic [DATA_W-1:0] o_rdata2_c
);

    logic [DATA_W-1:0] r_regs [NREGS];

    // Storage update; an index >= NREGS matches no entry and is dropped
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i_we_a && (i_waddr_a == AW'(i))) begin
                    r_regs[i] <= i_wdata_a;
                end else if (i_we_b && (i_waddr_b == AW'(i))) begin
                    r_regs[i] <= i_wdata_b;
                end
            end
        end
    end

    // Read port 1: port-A bypass, then port-B bypass, then storage
    always_comb begin
        o_rdata1_c = '0;
        if (i_we_a && (i_raddr1 == i_waddr_a)) begin
            o_rdata1_c = i_wdata_a;
        end else if (i_we_b && (i_raddr1 == i_waddr_b)) begin
            o_rdata1_c = i_wdata_b;
        end else if (32'(i_raddr1) < NREGS) begin
            o_rdata1_c = r_regs[i_raddr1];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        o_rdata2_c = '0;
        if (i_we_a && (i_raddr2 == i_waddr_a)) begin
            o_rdata2_c = i_wdata_a;
        end else if (i_we_b && (i_raddr2 == i_waddr_b)) begin
            o_rdata2_c = i_wdata_b;
        end else if (32'(i_raddr2) < NREGS) begin
            o_rdata2_c = r_regs[i_raddr2];
        end
    end

endmodule

// File: rtl/qrisc32_wb.sv
// Write-back stage: commits the MEM-stage result into the register file,
// exposes bypassed read ports to ID, a registered last-writeback tap for EX
// forwarding/trace, and a committed-entry counter.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pipe_wb_in            MEM-stage output payload
//   pipe_stall            MEM stall; blocks all commits this cycle
//   rd_addr1/rd_data1     read port 1 (combinational, bypassed)
//   rd_addr2/rd_data2     read port 2 (combinational, bypassed)
//   wb_valid/addr/data    registered tap of the last port-A commit
//   retired_cnt           count of cycles with any commit (wraps)
//   verbose               per-commit trace enable
module qrisc32_wb
    import risc_pack::*;
#(
    parameter int unsigned NREGS  = REG_NUM,
    parameter int unsigned DATA_W = XLEN,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  pipe_struct        pipe_wb_in,
    input  logic              pipe_stall,
    input  logic [AW-1:0]     rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retired_cnt,
    input  logic              verbose
);

    logic              w_ca;
    logic              w_cb;
    logic [AW-1:0]     w_addr_a;
    logic [AW-1:0]     w_addr_b;
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;

    logic              r_wb_valid;
    logic [AW-1:0]     r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [31:0]       r_retired_cnt;

    // Commit enables: a stalled entry is retried by MEM, so commit nothing now
    assign w_ca     = !pipe_stall && pipe_wb_in.write_reg;
    assign w_cb     = !pipe_stall && pipe_wb_in.incr_r2_enable;
    assign w_addr_a = AW'(pipe_wb_in.dst_r);
    assign w_addr_b = AW'(pipe_wb_in.src_r2);
    assign w_data_a = DATA_W'(pipe_wb_in.val_dst);
    assign w_data_b = DATA_W'(pipe_wb_in.val_r2);

    qrisc32_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W)
    ) u_regfile (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_we_a     (w_ca),
        .i_waddr_a  (w_addr_a),
        .i_wdata_a  (w_data_a),
        .i_we_b     (w_cb),
        .i_waddr_b  (w_addr_b),
        .i_wdata_b  (w_data_b),
        .i_raddr1   (rd_addr1),
        .o_rdata1_c (rd_data1),
        .i_raddr2   (rd_addr2),
        .o_rdata2_c (rd_data2)
    );

    // Writeback tap: valid pulses per port-A commit, addr/data hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_ca;
            if (w_ca) begin
                r_wb_addr <= w_addr_a;
                r_wb_data <= w_data_a;
            end
        end
    end

    // Retired counter: a dual-port commit counts as one entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
        end else if (w_ca || w_cb) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    // Commit trace, one line per active write port
    always_ff @(posedge clk) begin
        if (!reset && verbose) begin
            if (w_ca) begin
                $display("[WB stage] r%0d <= 0x%08h", w_addr_a, w_data_a);
            end
            if (w_cb) begin
                $display("[WB stage] r%0d <= 0x%08h", w_addr_b, w_data_b);
            end
        end
    end

    assign wb_valid    = r_wb_valid;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;
    assign retired_cnt = r_retired_cnt;

endmodule
